bg_ram_writer: RTL and testbench

CPU-side access engine for the background tile RAM pair (low byte / high byte, 2K x 8 each). Sits between the Z80 bus and the RAM port that the background layer shares with video fetch. It posts CPU writes into a small FIFO, commits them only in cycles where video fetch does not own the RAM, serves CPU reads in free slots, and drives the Z80 wait line so the CPU stalls only when it must.

---
 rtl/bg_ram_writer.sv | 249 ++++++++++++++++++++++++
 tb/tb_bg_ram_writer.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bg_ram_writer.sv
// bg_ram_writer: CPU-side access engine for the background tile RAM pair.
// CPU writes are posted into a small FIFO and committed in slots that video
// fetch does not own; CPU reads drain the FIFO, then use a free slot to read
// the RAM. The Z80 WAIT line is pulled low only while the CPU has to stall.
//
// Optional feature macro: BG_WR_FORWARD_EN
//   When defined, a read whose {hi_sel, addr} matches a posted write is
//   answered from the FIFO (newest match wins) without draining or a RAM read.
//
// Handshake: a CPU access is "any select low AND a strobe low". The done flag
// marks that the current access has been served; it is cleared the cycle
// after the strobe or select goes away, so each strobe causes one push/read.
// cpu_wait_n is the Z80-side stall: the CPU must hold its strobe, address and
// data stable while cpu_wait_n is low.
module bg_ram_writer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        master_clk,
  input  logic        reset,
  input  logic [10:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  input  logic        bg_cs_lo_n,
  input  logic        bg_cs_hi_n,
  input  logic        z80_wr_n,
  input  logic        z80_rd_n,
  output logic [7:0]  cpu_dout,
  output logic        cpu_wait_n,
  input  logic        vid_slot,
  output logic [10:0] ram_addr,
  output logic [7:0]  ram_din,
  output logic        ram_we_lo,
  output logic        ram_we_hi,
  input  logic [7:0]  ram_q_lo,
  input  logic [7:0]  ram_q_hi,
  output logic [1:0]  dbg_state_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef struct packed {
    logic        hi;
    logic [10:0] addr;
    logic [7:0]  data;
  } entry_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_RD_ISSUE = 2'd2,
    ST_RD_CAP   = 2'd3
  } state_t;

  // ---------------------------------------------------------------------
  // CPU access decode
  // ---------------------------------------------------------------------
  logic sel_any;
  logic hi_sel;
  logic acc_any;
  logic wr_acc;
  logic rd_acc;

  // Low byte wins when both selects are low, so hi is used only when lo is idle.
  assign sel_any = ~bg_cs_lo_n | ~bg_cs_hi_n;
  assign hi_sel  = bg_cs_lo_n;
  assign acc_any = sel_any & (~z80_wr_n | ~z80_rd_n);
  assign wr_acc  = sel_any & ~z80_wr_n;
  assign rd_acc  = sel_any & ~z80_rd_n & z80_wr_n;

  // ---------------------------------------------------------------------
  // Write-posting FIFO
  // ---------------------------------------------------------------------
  entry_t         mem_q [FIFO_DEPTH];
  logic [CW-1:0]  wr_ptr_q;
  logic [CW-1:0]  rd_ptr_q;
  logic           fifo_empty;
  logic           fifo_full;
  logic           push;
  logic           pop;
  entry_t         head;

  state_t         state_q;
  state_t         state_d;
  logic           done_q;
  logic           done_d;
  logic [7:0]     cpu_dout_q;
  logic [7:0]     cpu_dout_d;
  logic           rd_hi_q;
  logic           rd_hi_d;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Full is judged on the current pointers: a pop in the same cycle does
  // not let a stalled write in until the following cycle.
  assign push = wr_acc & ~done_q & ~fifo_full;

  // The read issue cycle owns the RAM port, so commits pause there.
  assign pop  = ~fifo_empty & ~vid_slot & (state_q != ST_RD_ISSUE);

  assign head = mem_q[rd_ptr_q[AW-1:0]];

  // FIFO storage: written on push, no reset needed (pointers gate validity).
  always_ff @(posedge master_clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {hi_sel, cpu_addr, cpu_din};
    end
  end

  // FIFO pointers; the extra MSB separates full from empty.
  always_ff @(posedge master_clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + CW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + CW'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Optional read forwarding from posted writes
  // ---------------------------------------------------------------------
  logic       fwd_hit;
  logic [7:0] fwd_data;

`ifdef BG_WR_FORWARD_EN
  logic [CW-1:0] fifo_count;
  logic [AW-1:0] fwd_idx;

  assign fifo_count = wr_ptr_q - rd_ptr_q;

  // Walk oldest to newest so the newest matching entry ends up selected.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = 8'h00;
    fwd_idx  = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      fwd_idx = rd_ptr_q[AW-1:0] + AW'(i);
      if ((CW'(i) < fifo_count) &&
          (mem_q[fwd_idx].hi == hi_sel) &&
          (mem_q[fwd_idx].addr == cpu_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = mem_q[fwd_idx].data;
      end
    end
  end
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = 8'h00;
`endif

  // ---------------------------------------------------------------------
  // Read FSM and done flag
  // ---------------------------------------------------------------------

  // State, done flag, read data and captured byte select registers.
  always_ff @(posedge master_clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      done_q     <= 1'b0;
      cpu_dout_q <= 8'h00;
      rd_hi_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      cpu_dout_q <= cpu_dout_d;
      rd_hi_q    <= rd_hi_d;
    end
  end

  // Next-state logic: drain posted writes, issue the RAM read, capture data.
  always_comb begin
    state_d    = state_q;
    done_d     = done_q;
    cpu_dout_d = cpu_dout_q;
    rd_hi_d    = rd_hi_q;

    if (!acc_any) begin
      done_d = 1'b0;
    end else if (push) begin
      done_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (rd_acc && !done_q) begin
          if (fwd_hit) begin
            cpu_dout_d = fwd_data;
            done_d     = 1'b1;
          end else if (fifo_empty) begin
            state_d = ST_RD_ISSUE;
          end else begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (!rd_acc) begin
          state_d = ST_IDLE;
        end else if (fifo_empty) begin
          state_d = ST_RD_ISSUE;
        end
      end
      ST_RD_ISSUE: begin
        if (!rd_acc) begin
          state_d = ST_IDLE;
        end else if (!vid_slot) begin
          state_d = ST_RD_CAP;
          rd_hi_d = hi_sel;
        end
      end
      ST_RD_CAP: begin
        state_d = ST_IDLE;
        if (rd_acc) begin
          cpu_dout_d = rd_hi_q ? ram_q_hi : ram_q_lo;
          done_d     = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // RAM port and CPU-side outputs
  // ---------------------------------------------------------------------

  // RAM port mux: read address in the issue slot, otherwise the FIFO head.
  always_comb begin
    ram_addr  = 11'h000;
    ram_din   = 8'h00;
    ram_we_lo = 1'b0;
    ram_we_hi = 1'b0;
    if ((state_q == ST_RD_ISSUE) && !vid_slot) begin
      ram_addr = cpu_addr;
    end else if (pop) begin
      ram_addr  = head.addr;
      ram_din   = head.data;
      ram_we_lo = ~head.hi;
      ram_we_hi = head.hi;
    end
  end

  assign cpu_wait_n  = ~((wr_acc & ~done_q & fifo_full) | (rd_acc & ~done_q));
  assign cpu_dout    = cpu_dout_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bg_ram_writer.sv
// tb_bg_ram_writer: directed bench for bg_ram_writer with a behavioural
// RAM pair model and a commit monitor feeding an observed-write queue.
module tb_bg_ram_writer;

  logic        master_clk;
  logic        reset;
  logic [10:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic        bg_cs_lo_n;
  logic        bg_cs_hi_n;
  logic        z80_wr_n;
  logic        z80_rd_n;
  logic [7:0]  cpu_dout;
  logic        cpu_wait_n;
  logic        vid_slot;
  logic [10:0] ram_addr;
  logic [7:0]  ram_din;
  logic        ram_we_lo;
  logic        ram_we_hi;
  logic [7:0]  ram_q_lo;
  logic [7:0]  ram_q_hi;
  logic [1:0]  dbg_state_o;

  int checks;
  int failures;

  logic [19:0] exp_q[$];
  logic [19:0] obs_q[$];

  logic [7:0] mem_lo [2048];
  logic [7:0] mem_hi [2048];

  bg_ram_writer #(.FIFO_DEPTH(4)) dut (
    .master_clk (master_clk),
    .reset      (reset),
    .cpu_addr   (cpu_addr),
    .cpu_din    (cpu_din),
    .bg_cs_lo_n (bg_cs_lo_n),
    .bg_cs_hi_n (bg_cs_hi_n),
    .z80_wr_n   (z80_wr_n),
    .z80_rd_n   (z80_rd_n),
    .cpu_dout   (cpu_dout),
    .cpu_wait_n (cpu_wait_n),
    .vid_slot   (vid_slot),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_we_lo  (ram_we_lo),
    .ram_we_hi  (ram_we_hi),
    .ram_q_lo   (ram_q_lo),
    .ram_q_hi   (ram_q_hi),
    .dbg_state_o(dbg_state_o)
  );

  // Clock and reset block
  initial master_clk = 1'b0;
  always #5 master_clk = ~master_clk;

  // RAM pair model: synchronous write, one-cycle registered read.
  always @(posedge master_clk) begin
    if (ram_we_lo) mem_lo[ram_addr] <= ram_din;
    if (ram_we_hi) mem_hi[ram_addr] <= ram_din;
    ram_q_lo <= mem_lo[ram_addr];
    ram_q_hi <= mem_hi[ram_addr];
  end

  // Commit monitor: every write-enable cycle becomes one observed entry.
  always @(negedge master_clk) begin
    if (!reset && (ram_we_lo || ram_we_hi)) begin
      obs_q.push_back({ram_we_hi, ram_addr, ram_din});
    end
  end

  // ---------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------
  task automatic tick();
    @(posedge master_clk);
    #1;
  endtask

  task automatic release_bus();
    bg_cs_lo_n = 1'b1;
    bg_cs_hi_n = 1'b1;
    z80_wr_n   = 1'b1;
    z80_rd_n   = 1'b1;
  endtask

  task automatic do_write(input logic lo_n, input logic hi_n,
                          input logic [10:0] a, input logic [7:0] d,
                          output int waits);
    bg_cs_lo_n = lo_n;
    bg_cs_hi_n = hi_n;
    cpu_addr   = a;
    cpu_din    = d;
    z80_wr_n   = 1'b0;
    waits      = 0;
    @(negedge master_clk);
    while (!cpu_wait_n && waits < 100) begin
      waits++;
      @(negedge master_clk);
    end
    tick();
    release_bus();
    tick();
  endtask

  // vid_slot is held high for the first vid_cycles cycles of the read.
  task automatic do_read(input logic lo_n, input logic hi_n,
                         input logic [10:0] a, input int vid_cycles,
                         output int waits);
    vid_slot   = (vid_cycles > 0);
    bg_cs_lo_n = lo_n;
    bg_cs_hi_n = hi_n;
    cpu_addr   = a;
    z80_rd_n   = 1'b0;
    waits      = 0;
    @(negedge master_clk);
    while (!cpu_wait_n && waits < 100) begin
      waits++;
      @(posedge master_clk);
      #1;
      if (waits == vid_cycles) vid_slot = 1'b0;
      @(negedge master_clk);
    end
    tick();
    release_bus();
    vid_slot = 1'b0;
    tick();
  endtask

  // ---------------------------------------------------------------------
  // Scenario tasks
  // ---------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge master_clk);
    @(negedge master_clk);
    checks++;
    if (cpu_wait_n !== 1'b1) begin
      failures++; $display("FAIL reset_wait_n got=%0b exp=1", cpu_wait_n);
    end
    checks++;
    if (cpu_dout !== 8'h00) begin
      failures++; $display("FAIL reset_dout got=%02h exp=00", cpu_dout);
    end
    checks++;
    if ({ram_we_lo, ram_we_hi} !== 2'b00) begin
      failures++; $display("FAIL reset_we got=%02b exp=00", {ram_we_lo, ram_we_hi});
    end
    checks++;
    if (ram_addr !== 11'h000 || ram_din !== 8'h00) begin
      failures++; $display("FAIL reset_ram_port got=%03h/%02h exp=000/00", ram_addr, ram_din);
    end
    checks++;
    if (dbg_state_o !== 2'd0) begin
      failures++; $display("FAIL reset_state got=%0d exp=0", dbg_state_o);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_write();
    vid_slot   = 1'b0;
    bg_cs_lo_n = 1'b0;
    bg_cs_hi_n = 1'b1;
    cpu_addr   = 11'h123;
    cpu_din    = 8'h5A;
    z80_wr_n   = 1'b0;
    @(negedge master_clk);
    checks++;
    if (cpu_wait_n !== 1'b1) begin
      failures++; $display("FAIL wr_wait_n got=%0b exp=1", cpu_wait_n);
    end
    tick();
    release_bus();
    @(negedge master_clk);
    checks++;
    if (ram_we_lo !== 1'b1 || ram_we_hi !== 1'b0) begin
      failures++; $display("FAIL wr_we got=lo%0b hi%0b exp=lo1 hi0", ram_we_lo, ram_we_hi);
    end
    checks++;
    if (ram_addr !== 11'h123) begin
      failures++; $display("FAIL wr_addr got=%03h exp=123", ram_addr);
    end
    checks++;
    if (ram_din !== 8'h5A) begin
      failures++; $display("FAIL wr_din got=%02h exp=5a", ram_din);
    end
    tick();
  endtask

  task automatic test_read_hi();
    int w;
    vid_slot = 1'b0;
    do_write(1'b1, 1'b0, 11'h7FF, 8'hC3, w);
    repeat (3) tick();
    do_read(1'b1, 1'b0, 11'h7FF, 0, w);
    checks++;
    if (w != 3) begin
      failures++; $display("FAIL rd_hi_waits got=%0d exp=3", w);
    end
    checks++;
    if (cpu_dout !== 8'hC3) begin
      failures++; $display("FAIL rd_hi_data got=%02h exp=c3", cpu_dout);
    end
  endtask

  task automatic test_back_to_back();
    int w;
    logic [19:0] e;
    logic [19:0] o;
    repeat (2) tick();
    obs_q.delete();
    exp_q.delete();
    vid_slot = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_write(1'b0, 1'b1, 11'h100 + 11'(i), 8'hA0 + 8'(i), w);
      exp_q.push_back({1'b0, 11'h100 + 11'(i), 8'hA0 + 8'(i)});
      checks++;
      if (w != 0) begin
        failures++; $display("FAIL b2b_wr%0d_waits got=%0d exp=0", i, w);
      end
    end
    // Fifth write hits a full FIFO while video owns the RAM.
    bg_cs_lo_n = 1'b1;
    bg_cs_hi_n = 1'b0;
    cpu_addr   = 11'h105;
    cpu_din    = 8'hB5;
    z80_wr_n   = 1'b0;
    exp_q.push_back({1'b1, 11'h105, 8'hB5});
    for (int c = 0; c < 3; c++) begin
      @(negedge master_clk);
      checks++;
      if (cpu_wait_n !== 1'b0) begin
        failures++; $display("FAIL b2b_full_wait%0d got=%0b exp=0", c, cpu_wait_n);
      end
      tick();
    end
    vid_slot = 1'b0;
    @(negedge master_clk);
    checks++;
    if (cpu_wait_n !== 1'b0) begin
      failures++; $display("FAIL b2b_pop_cycle_wait got=%0b exp=0", cpu_wait_n);
    end
    tick();
    @(negedge master_clk);
    checks++;
    if (cpu_wait_n !== 1'b1) begin
      failures++; $display("FAIL b2b_release_wait got=%0b exp=1", cpu_wait_n);
    end
    tick();
    release_bus();
    repeat (8) tick();
    checks++;
    if (obs_q.size() != 5) begin
      failures++; $display("FAIL b2b_commit_count got=%0d exp=5", obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++; $display("FAIL b2b_commit_order got=%05h exp=%05h", o, e);
      end
    end
  endtask

  task automatic test_read_after_write();
    int w;
    vid_slot = 1'b1;
    do_write(1'b0, 1'b1, 11'h040, 8'h11, w);
    do_read(1'b0, 1'b1, 11'h040, 4, w);
`ifdef BG_WR_FORWARD_EN
    checks++;
    if (w != 1) begin
      failures++; $display("FAIL raw_fwd_waits got=%0d exp=1", w);
    end
`else
    checks++;
    if (w < 6 || w >= 100) begin
      failures++; $display("FAIL raw_drain_waits got=%0d exp=6..99", w);
    end
`endif
    checks++;
    if (cpu_dout !== 8'h11) begin
      failures++; $display("FAIL raw_data got=%02h exp=11", cpu_dout);
    end
    repeat (3) tick();
  endtask

  task automatic test_both_sel();
    int w;
    vid_slot   = 1'b0;
    bg_cs_lo_n = 1'b0;
    bg_cs_hi_n = 1'b0;
    cpu_addr   = 11'h2AA;
    cpu_din    = 8'h77;
    z80_wr_n   = 1'b0;
    tick();
    release_bus();
    @(negedge master_clk);
    checks++;
    if (ram_we_lo !== 1'b1 || ram_we_hi !== 1'b0) begin
      failures++; $display("FAIL both_sel_we got=lo%0b hi%0b exp=lo1 hi0", ram_we_lo, ram_we_hi);
    end
    checks++;
    if (ram_addr !== 11'h2AA || ram_din !== 8'h77) begin
      failures++; $display("FAIL both_sel_port got=%03h/%02h exp=2aa/77", ram_addr, ram_din);
    end
    tick();
    do_read(1'b0, 1'b1, 11'h2AA, 0, w);
    checks++;
    if (cpu_dout !== 8'h77 || w != 3) begin
      failures++; $display("FAIL both_sel_readback got=%02h/%0d exp=77/3", cpu_dout, w);
    end
  endtask

  task automatic test_hi_write();
    vid_slot   = 1'b0;
    bg_cs_lo_n = 1'b1;
    bg_cs_hi_n = 1'b0;
    cpu_addr   = 11'h000;
    cpu_din    = 8'h3C;
    z80_wr_n   = 1'b0;
    tick();
    release_bus();
    @(negedge master_clk);
    checks++;
    if (ram_we_hi !== 1'b1 || ram_we_lo !== 1'b0) begin
      failures++; $display("FAIL hi_wr_we got=lo%0b hi%0b exp=lo0 hi1", ram_we_lo, ram_we_hi);
    end
    checks++;
    if (ram_addr !== 11'h000 || ram_din !== 8'h3C) begin
      failures++; $display("FAIL hi_wr_port got=%03h/%02h exp=000/3c", ram_addr, ram_din);
    end
    tick();
  endtask

  task automatic test_reset_mid_drain();
    int w;
    repeat (3) tick();
    vid_slot = 1'b1;
    for (int i = 0; i < 3; i++) begin
      do_write(1'b0, 1'b1, 11'h010 + 11'(i), 8'h60 + 8'(i), w);
    end
    obs_q.delete();
    vid_slot = 1'b0;
    tick();
    checks++;
    if (obs_q.size() != 1) begin
      failures++; $display("FAIL mid_drain_progress got=%0d exp=1", obs_q.size());
    end
    reset = 1'b1;
    @(negedge master_clk);
    checks++;
    if (cpu_wait_n !== 1'b1) begin
      failures++; $display("FAIL mid_rst_wait_n got=%0b exp=1", cpu_wait_n);
    end
    checks++;
    if (cpu_dout !== 8'h00) begin
      failures++; $display("FAIL mid_rst_dout got=%02h exp=00", cpu_dout);
    end
    checks++;
    if ({ram_we_lo, ram_we_hi} !== 2'b00) begin
      failures++; $display("FAIL mid_rst_we got=%02b exp=00", {ram_we_lo, ram_we_hi});
    end
    tick();
    reset = 1'b0;
    obs_q.delete();
    repeat (6) tick();
    checks++;
    if (obs_q.size() != 0) begin
      failures++; $display("FAIL mid_rst_no_commit got=%0d exp=0", obs_q.size());
    end
    checks++;
    if (dbg_state_o !== 2'd0) begin
      failures++; $display("FAIL mid_rst_state got=%0d exp=0", dbg_state_o);
    end
  endtask

  // ---------------------------------------------------------------------
  // Sequence and final report
  // ---------------------------------------------------------------------
  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    vid_slot = 1'b0;
    cpu_addr = 11'h000;
    cpu_din  = 8'h00;
    release_bus();

    test_reset();
    test_single_write();
    test_read_hi();
    test_back_to_back();
    test_read_after_write();
    test_both_sel();
    test_hi_write();
    test_reset_mid_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
